// File: rtl/gray_step_sequencer_if.sv
// Command/status bundle between a controller and the Gray-code step sequencer.
// The controller side is the master; the sequencer side is the slave.
interface gray_step_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_data;
    logic              hold;
    logic              abort;
    logic [WIDTH-1:0]  gray;
    logic [WIDTH-1:0]  bin;
    logic              busy;
    logic              done;
    logic              wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_data, hold, abort,
        input  cmd_ready, gray, bin, busy, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, hold, abort,
        output cmd_ready, gray, bin, busy, done, wrap
    );
endinterface

// File: rtl/gray_step_sequencer.sv
// Command-driven Gray-code counter: LOAD a value, or RUN a programmed number of
// up/down steps with hold/abort, publishing Gray, binary and busy/done/wrap status.
module gray_step_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    gray_step_sequencer_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0]        OP_LOAD  = 2'b01;
    localparam logic [WIDTH-1:0]  BIN_MAX  = '1;
    localparam logic [WIDTH-1:0]  BIN_ONE  = 1;
    localparam logic [STEP_W-1:0] STEP_ONE = 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  gray_q, gray_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              down_q, down_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic [WIDTH-1:0]  bin_cur;
    logic [WIDTH-1:0]  bin_next;
    logic              accept;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign bin_cur  = gray2bin(gray_q);
    assign bin_next = down_q ? (bin_cur - BIN_ONE) : (bin_cur + BIN_ONE);
    assign accept   = bus.cmd_valid && (state_q == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gray_q  <= '0;
            rem_q   <= '0;
            down_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            rem_q   <= rem_d;
            down_q  <= down_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        rem_d   = rem_q;
        down_d  = down_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.cmd_op == OP_LOAD) begin
                        gray_d = bin2gray(bus.cmd_data[WIDTH-1:0]);
                        done_d = 1'b1;
                    end else if (bus.cmd_op[1]) begin
                        // A zero-length run completes immediately without leaving IDLE
                        down_d = bus.cmd_op[0];
                        if (bus.cmd_data == '0) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d   = bus.cmd_data;
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (!bus.hold) begin
                    gray_d = bin2gray(bin_next);
                    rem_d  = rem_q - STEP_ONE;
                    wrap_d = down_q ? (bin_cur == '0) : (bin_cur == BIN_MAX);
                    if (rem_q == STEP_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.gray      = gray_q;
    assign bus.bin       = bin_cur;
    assign bus.done      = done_q;
    assign bus.wrap      = wrap_q;

endmodule
